// File: rtl/debounce.sv
// Pushbutton debouncer with press/release/long-press pulses; toggle_o output only when DEBOUNCE_TOGGLE_EN is defined.
// Latency: 2+DIV cycles from a clean btn_i edge to press_o/release_o; no backpressure, all outputs registered.
`ifndef DEFAULT_FREQ
`define DEFAULT_FREQ 100_000_000
`endif

module debounce #(
   parameter int FREQ       = `DEFAULT_FREQ,
   parameter int MSECS      = 20,
   parameter int LONG_MSECS = 1000
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic btn_i,
   output logic level_o,
   output logic press_o,
   output logic release_o,
   output logic long_o
`ifdef DEBOUNCE_TOGGLE_EN
   ,
   output logic toggle_o
`endif
);

   localparam longint DIV  = longint'(FREQ) * MSECS / 1000;
   localparam longint LDIV = longint'(FREQ) * LONG_MSECS / 1000;
   localparam int     CW   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int     LW   = $clog2(LDIV + 1);

   typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;

   state_t          state_q, state_d;
   logic [1:0]      sync_q;
   logic            s;
   logic [CW-1:0]   cnt_q;
   logic [LW-1:0]   lcnt_q;
   logic            cnt_done, lcnt_hit;
   logic            level_d, press_d, release_d, long_d;

   assign s        = sync_q[1];
   assign cnt_done = (cnt_q == CW'(DIV - 1));
   assign lcnt_hit = (lcnt_q == LW'(LDIV - 1));

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         sync_q  <= '0;
         state_q <= IDLE;
      end else begin
         sync_q  <= {sync_q[0], btn_i};
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:         if (s) state_d = PRESS_WAIT;
         PRESS_WAIT:   if (!s) state_d = IDLE;
                       else if (cnt_done) state_d = PRESSED;
         PRESSED:      if (!s) state_d = RELEASE_WAIT;
         RELEASE_WAIT: if (s) state_d = PRESSED;
                       else if (cnt_done) state_d = IDLE;
         default:      state_d = IDLE;
      endcase
   end

   always_comb begin
      press_d   = (state_q == PRESS_WAIT) && s && cnt_done;
      release_d = (state_q == RELEASE_WAIT) && !s && cnt_done;
      long_d    = (state_q == PRESSED) && lcnt_hit;
      level_d   = level_o;
      if (press_d)   level_d = 1'b1;
      if (release_d) level_d = 1'b0;
   end

   // lcnt parks at LDIV after the long pulse; while releasing it stops one short so long_o can only fire from PRESSED
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         cnt_q  <= '0;
         lcnt_q <= '0;
      end else begin
         case (state_q)
            IDLE: cnt_q <= '0;
            PRESS_WAIT: begin
               lcnt_q <= '0;
               if (s && !cnt_done) cnt_q <= cnt_q + CW'(1);
            end
            PRESSED: begin
               cnt_q <= '0;
               if (lcnt_hit)                       lcnt_q <= LW'(LDIV);
               else if (lcnt_q < LW'(LDIV - 1))    lcnt_q <= lcnt_q + LW'(1);
            end
            RELEASE_WAIT: begin
               if (!s && !cnt_done)             cnt_q  <= cnt_q + CW'(1);
               if (lcnt_q < LW'(LDIV - 1))      lcnt_q <= lcnt_q + LW'(1);
            end
            default: cnt_q <= '0;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         level_o   <= 1'b0;
         press_o   <= 1'b0;
         release_o <= 1'b0;
         long_o    <= 1'b0;
      end else begin
         level_o   <= level_d;
         press_o   <= press_d;
         release_o <= release_d;
         long_o    <= long_d;
      end
   end

`ifdef DEBOUNCE_TOGGLE_EN
   always_ff @(posedge clk_i) begin
      if (!rst_ni)      toggle_o <= 1'b0;
      else if (press_d) toggle_o <= ~toggle_o;
   end
`endif

endmodule

// File: tb/tb_debounce.sv
// Directed bench for debounce with FREQ=1000, MSECS=5, LONG_MSECS=20 (DIV=5, LDIV=20).
module tb_debounce;

   logic clk_i = 1'b0;
   logic rst_ni, btn_i;
   logic level_o, press_o, release_o, long_o;
`ifdef DEBOUNCE_TOGGLE_EN
   logic toggle_o;
   logic [2:0] tog_exp;
`endif
   int total = 0;
   int passed = 0;
   int failed = 0;

   always #5 clk_i = ~clk_i;

   debounce #(.FREQ(1000), .MSECS(5), .LONG_MSECS(20)) dut (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .btn_i     (btn_i),
      .level_o   (level_o),
      .press_o   (press_o),
      .release_o (release_o),
      .long_o    (long_o)
`ifdef DEBOUNCE_TOGGLE_EN
      ,
      .toggle_o  (toggle_o)
`endif
   );

   task automatic chk(input string tag, input int c, input logic obs, input logic exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s cycle %0d: observed %b expected %b", tag, c, obs, exp);
      end
   endtask

   // Cycle c is the c-th rising edge after the inputs for it are driven; outputs sampled 1 time unit later.
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic settle();
      btn_i = 1'b0;
      repeat (12) tick();
   endtask

   // Hold btn_i high for cycles 0..39 with an optional 2-cycle dropout starting at drop_at.
   task automatic run_press(input string tag, input int drop_at);
      for (int c = 0; c <= 52; c++) begin
         btn_i = (c < 40) && !(c == drop_at || c == drop_at + 1);
         tick();
         chk({tag, ".press"},   c, press_o,   c == 7);
         chk({tag, ".long"},    c, long_o,    c == 27);
         chk({tag, ".release"}, c, release_o, c == 47);
         chk({tag, ".level"},   c, level_o,   c >= 7 && c < 47);
      end
   endtask

   initial begin
      rst_ni = 1'b0;
      btn_i  = 1'b0;
      repeat (3) tick();
      chk("rst.level",   0, level_o,   1'b0);
      chk("rst.press",   0, press_o,   1'b0);
      chk("rst.release", 0, release_o, 1'b0);
      chk("rst.long",    0, long_o,    1'b0);
`ifdef DEBOUNCE_TOGGLE_EN
      chk("rst.toggle",  0, toggle_o,  1'b0);
`endif
      rst_ni = 1'b1;
      settle();

      run_press("hold", -10);
      settle();

      // 3-cycle pulse, 1-cycle gap, 4-cycle pulse: both shorter than DIV after sync
      for (int c = 0; c <= 14; c++) begin
         btn_i = (c <= 2) || (c >= 4 && c <= 7);
         tick();
         chk("glitch.press", c, press_o, 1'b0);
         chk("glitch.level", c, level_o, 1'b0);
      end
      settle();

      run_press("dropout", 15);
      settle();

      // Reset at cycles 12-13 mid-press, btn_i still held: abort, then a fresh press at 14+7
      for (int c = 0; c <= 30; c++) begin
         btn_i  = 1'b1;
         rst_ni = !(c == 12 || c == 13);
         tick();
         chk("rstmid.press",   c, press_o,   c == 7 || c == 21);
         chk("rstmid.release", c, release_o, 1'b0);
         chk("rstmid.long",    c, long_o,    1'b0);
         chk("rstmid.level",   c, level_o,   (c >= 7 && c < 12) || c >= 21);
      end
      settle();
      chk("rstmid.idle_level", 0, level_o, 1'b0);

`ifdef DEBOUNCE_TOGGLE_EN
      rst_ni = 1'b0;
      tick();
      chk("tog.reset", 0, toggle_o, 1'b0);
      rst_ni = 1'b1;
      settle();
      tog_exp = 3'b101;
      for (int p = 0; p < 3; p++) begin
         btn_i = 1'b1;
         repeat (12) tick();
         chk("tog.after_press", p, toggle_o, tog_exp[p]);
         settle();
         chk("tog.after_release", p, toggle_o, tog_exp[p]);
      end
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
